wlfsr_pattern_gen: RTL and testbench
====================================

# wlfsr_pattern_gen

Parametrised weighted-LFSR test-pattern generator. A Galois LFSR of configurable length and polynomial feeds CHANNELS weighted output bits, each formed by an AND chain over its own group of LFSR bits. The block runs bounded or free-running pattern bursts under a start/abort FSM, with valid/ready backpressure on the pattern stream. It sits in front of BIST/test-stimulus consumers and replaces the fixed 20-bit, 5-output generator.

## Interface
- WIDTH, 20: LFSR length; must be ≥ CHANNELS*GROUP.
- TAPS, 20'h00008: Galois feedback mask (bit i set: XOR feedback into stage i); default gives x^20+x^3+1.
- CHANNELS, 5: number of weighted output bits.
- GROUP, 4: LFSR bits per channel, i.e. maximum AND depth.
- SEL_W, $clog2(GROUP): width of weight_sel.
- CNT_W, 32: pattern/statistics counter width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a burst; ignored unless FSM is IDLE.
- abort  in  1  terminates RUN; ignored in other states.
- seed  in  WIDTH  LFSR initial state, sampled on accepted start.
- weight_sel  in  SEL_W  AND depth minus one, sampled on accepted start.
- invert  in  1  invert all channel outputs, sampled on accepted start.
- num_patterns  in  CNT_W  burst length in beats; 0 = free-running.
- pat_data  out  CHANNELS  weighted pattern, bit c = channel c.
- pat_valid  out  1  pat_data valid.
- pat_ready  in  1  consumer accepts beat when pat_valid && pat_ready.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse at normal burst completion.
- seed_zero  out  1  sticky; set when an all-zero seed was substituted.
- ones_count  out  CNT_W  total ones in accepted beats (stats).
- pat_count  out  CNT_W  accepted beats in current/last burst.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → RUN; same edge loads lfsr←seed, latches weight_sel/invert/num_patterns, clears pat_count, ones_count, seed_zero.
- Zero seed: lfsr←1 instead; seed_zero←1 (held until next accepted start or reset).
- RUN: pat_valid=1. On accept: lfsr advances one step; pat_count+1; ones_count += popcount(pat_data).
- Burst end: accept with pat_count+1 == latched num_patterns → DONE. num_patterns=0 never ends.
- abort in RUN → IDLE next edge, no done pulse; abort wins over a simultaneous last accept (beat counted, done not raised).
- DONE: done=1, pat_valid=0, one cycle → IDLE.
- No accept → lfsr and pat_data hold (stall is lossless).
- LFSR step: next[0]=s[WIDTH-1]; next[i]=s[i-1] ^ (TAPS[i] & s[WIDTH-1]), i≥1.
- Weighting: k = latched weight_sel; g = c*GROUP+GROUP-1; raw[c] = AND of s[g-j] for j=0..k, giving P(1)=2^-(k+1); pat_data[c] = raw[c] ^ invert.
- weight_sel ≥ GROUP saturates to GROUP-1.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset values: pat_data=0, pat_valid=0, busy=0, done=0, seed_zero=0, ones_count=0, pat_count=0, lfsr=0.
- start at edge N → pat_valid=1 and pat_data=f(seed) from cycle N+1.
- pat_data is combinational from the lfsr and latched controls; it changes only on the edge after an accept.
- Last accept at edge M → done=1 in cycle M+1, busy=0 from cycle M+2.
- Reset mid-burst: all state returns to reset values on that edge; no done pulse.

## Configuration
- WLFSR_STATS_EN defined: ones_count and pat_count are implemented as above.
- WLFSR_STATS_EN undefined: both outputs are tied to 0 and the ones-counter and popcount logic is removed. The internal beat counter for num_patterns is always present.

## Test plan
- Defaults, seed=20'h00008, weight_sel=0, invert=0, num_patterns=3, ready=1 → pat_data beats 5'b00001, 00000, 00000; done pulses one cycle after the third accept; pat_count=3.
- Free-running, seed=1, ready=1, abort after 1048575 accepts → internal LFSR equals 20'h00001 again, with no earlier repeat (maximal period).
- Same run, weight_sel=3 → ones_count=327680 (65536 per channel). weight_sel=0 → 2621440. weight_sel=0 with invert=1 → 2621435.
- seed=0, start → seed_zero=1 and the stream matches a seed=1 run; next start with nonzero seed → seed_zero=0.
- pat_ready toggles 1,0,0,1 during RUN → pat_data is held across stalls and the sequence matches the ready=1 run; start pulsed mid-RUN is ignored.
- abort coincident with the last accept → IDLE next cycle, no done, pat_count=num_patterns. Reset mid-RUN → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/wlfsr_pattern_gen.sv
// ---------------------------------------------------------------------------
// wlfsr_pattern_gen
//
// Weighted-LFSR test-pattern generator. A Galois LFSR drives CHANNELS output
// bits. Each bit is the AND of the top (weight_sel+1) bits of its own
// GROUP-wide slice of the LFSR, so it is 1 with probability 2^-(weight_sel+1).
// A start/abort FSM (IDLE/RUN/DONE) runs bounded or free-running bursts. The
// pattern stream uses valid/ready handshaking, and the LFSR steps only on an
// accepted beat.
//
// Optional feature macro: WLFSR_STATS_EN
//   defined   : ones_count / pat_count report burst statistics
//   undefined : both outputs are tied to 0 and the popcount logic is removed
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   start         begin a burst (accepted only in IDLE)
//   abort         end a burst early (RUN only, no done pulse)
//   seed          LFSR start value (0 is replaced by 1, which sets seed_zero)
//   weight_sel    AND depth minus one (saturates to GROUP-1)
//   invert        invert every channel output
//   num_patterns  burst length in beats, 0 = free-running
//   pat_data      weighted pattern, bit c = channel c
//   pat_valid     pat_data valid (RUN)
//   pat_ready     consumer accepts the beat when pat_valid && pat_ready
//   busy          FSM not IDLE
//   done          one-cycle pulse after normal burst completion
//   seed_zero     sticky flag: an all-zero seed was substituted
//   ones_count    total ones in accepted beats
//   pat_count     accepted beats in the current or last burst
//
// WIDTH must be at least CHANNELS*GROUP.
// ---------------------------------------------------------------------------
module wlfsr_pattern_gen #(
   parameter int                WIDTH    = 20,
   parameter logic [WIDTH-1:0]  TAPS     = WIDTH'(20'h00008),
   parameter int                CHANNELS = 5,
   parameter int                GROUP    = 4,
   parameter int                SEL_W    = (GROUP > 1) ? $clog2(GROUP) : 1,
   parameter int                CNT_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [WIDTH-1:0]    seed,
   input  logic [SEL_W-1:0]    weight_sel,
   input  logic                invert,
   input  logic [CNT_W-1:0]    num_patterns,
   output logic [CHANNELS-1:0] pat_data,
   output logic                pat_valid,
   input  logic                pat_ready,
   output logic                busy,
   output logic                done,
   output logic                seed_zero,
   output logic [CNT_W-1:0]    ones_count,
   output logic [CNT_W-1:0]    pat_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     lfsr_q, lfsr_d;
   logic [SEL_W-1:0]     weight_q, weight_d;
   logic                 invert_q, invert_d;
   logic [CNT_W-1:0]     num_q, num_d;
   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic                 seed_zero_q, seed_zero_d;

   logic                 start_acc;
   logic                 accept;
   logic [CNT_W-1:0]     beat_cnt_inc;
   logic [WIDTH-1:0]     lfsr_step;
   logic [SEL_W-1:0]     weight_sat;
   logic [CHANNELS-1:0]  raw;

   assign start_acc    = (state_q == S_IDLE) && start;
   assign accept       = pat_valid && pat_ready;
   assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

   // Galois step: rotate left, and fold the outgoing MSB into every tapped
   // stage above bit 0. Bit 0 always takes the MSB, so TAPS[0] is ignored.
   assign lfsr_step = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1]}
                    ^ ({TAPS[WIDTH-1:1], 1'b0} & {WIDTH{lfsr_q[WIDTH-1]}});

   // The compare is done at 32 bits so that it stays meaningful when
   // SEL_W can encode values of GROUP or more.
   assign weight_sat = (32'(weight_sel) > 32'(GROUP - 1)) ? SEL_W'(GROUP - 1)
                                                          : weight_sel;

   // ---------------- FSM: state register ----------------
   // NOTE: every clocked block uses non-blocking (<=) assignments, so all
   // registers update together from values sampled before the edge.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // NOTE: each combinational block assigns a default first. An output left
   // unassigned on any path would otherwise be inferred as a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            // abort takes priority over completing on the last beat
            if (abort)
               state_d = S_IDLE;
            else if (accept && (num_q != '0) && (beat_cnt_inc == num_q))
               state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      pat_valid = (state_q == S_RUN);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      lfsr_d      = lfsr_q;
      weight_d    = weight_q;
      invert_d    = invert_q;
      num_d       = num_q;
      beat_cnt_d  = beat_cnt_q;
      seed_zero_d = seed_zero_q;
      if (start_acc) begin
         // An all-zero state would lock the LFSR, so 1 is loaded instead.
         lfsr_d      = (seed == '0) ? WIDTH'(1) : seed;
         seed_zero_d = (seed == '0);
         weight_d    = weight_sat;
         invert_d    = invert;
         num_d       = num_patterns;
         beat_cnt_d  = '0;
      end else if (accept) begin
         lfsr_d     = lfsr_step;
         beat_cnt_d = beat_cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q      <= '0;
         weight_q    <= '0;
         invert_q    <= 1'b0;
         num_q       <= '0;
         beat_cnt_q  <= '0;
         seed_zero_q <= 1'b0;
      end else begin
         lfsr_q      <= lfsr_d;
         weight_q    <= weight_d;
         invert_q    <= invert_d;
         num_q       <= num_d;
         beat_cnt_q  <= beat_cnt_d;
         seed_zero_q <= seed_zero_d;
      end
   end

   assign seed_zero = seed_zero_q;

   // ---------------- weighting ----------------
   // Channel c ANDs bits g, g-1, ..., g-k of its slice, where g is the top bit
   // of the slice and k is the latched weight.
   always_comb begin
      raw = '1;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int j = 0; j < GROUP; j++) begin
            if (j <= int'(weight_q))
               raw[c] = raw[c] & lfsr_q[c*GROUP + GROUP - 1 - j];
         end
      end
   end

   assign pat_data = raw ^ {CHANNELS{invert_q}};

   // ---------------- statistics ----------------
`ifdef WLFSR_STATS_EN
   logic [CNT_W-1:0] ones_q, ones_d;
   logic [CNT_W-1:0] popcnt;

   always_comb begin
      popcnt = '0;
      for (int c = 0; c < CHANNELS; c++) popcnt = popcnt + CNT_W'(pat_data[c]);
   end

   always_comb begin
      ones_d = ones_q;
      if (start_acc)   ones_d = '0;
      else if (accept) ones_d = ones_q + popcnt;
   end

   always_ff @(posedge clk) begin
      if (reset) ones_q <= '0;
      else       ones_q <= ones_d;
   end

   assign ones_count = ones_q;
   assign pat_count  = beat_cnt_q;
`else
   assign ones_count = '0;
   assign pat_count  = '0;
`endif

endmodule

// File: tb/tb_wlfsr_pattern_gen.sv
module tb_wlfsr_pattern_gen;

`ifdef WLFSR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [19:0] seed;
   logic [1:0]  weight_sel;
   logic        invert;
   logic [31:0] num_patterns;
   logic [4:0]  pat_data;
   logic        pat_valid;
   logic        pat_ready;
   logic        busy;
   logic        done;
   logic        seed_zero;
   logic [31:0] ones_count;
   logic [31:0] pat_count;

   int n_tests = 0;
   int n_fail  = 0;

   wlfsr_pattern_gen dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .seed         (seed),
      .weight_sel   (weight_sel),
      .invert       (invert),
      .num_patterns (num_patterns),
      .pat_data     (pat_data),
      .pat_valid    (pat_valid),
      .pat_ready    (pat_ready),
      .busy         (busy),
      .done         (done),
      .seed_zero    (seed_zero),
      .ones_count   (ones_count),
      .pat_count    (pat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0]     seed;
      logic [1:0]      wsel;
      logic            inv;
      int              num;
      logic [4:0]      beats [4];
      int              ones;
      logic            sz;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic [19:0] s, logic [1:0] w, logic i, int n,
                               logic [4:0] b0, logic [4:0] b1, logic [4:0] b2,
                               logic [4:0] b3, int o, logic z);
      vec_t v;
      v.seed = s; v.wsel = w; v.inv = i; v.num = n;
      v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
      v.ones = o; v.sz = z;
      return v;
   endfunction

   task automatic do_start(input logic [19:0] s, input logic [1:0] w, input logic i,
                           input int n);
      seed = s; weight_sel = w; invert = i; num_patterns = 32'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_stats(input string tag, input int cnt, input int ones);
      check({tag, ".pat_count"},  pat_count,  STATS ? 64'(cnt)  : 64'd0);
      check({tag, ".ones_count"}, ones_count, STATS ? 64'(ones) : 64'd0);
   endtask

   // bounds the whole run in case the clock or a handshake stalls
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // expected beats are hand-derived from the Galois step with x^20+x^3+1
      vecs[0] = mk(20'h00008, 2'd0, 1'b0, 3, 5'h01, 5'h00, 5'h00, 5'h00, 1, 1'b0);
      vecs[1] = mk(20'h88888, 2'd0, 1'b0, 2, 5'h1F, 5'h01, 5'h00, 5'h00, 6, 1'b0);
      vecs[2] = mk(20'h00000, 2'd0, 1'b0, 4, 5'h00, 5'h00, 5'h00, 5'h01, 1, 1'b1);
      vecs[3] = mk(20'hFFFFF, 2'd3, 1'b0, 2, 5'h1F, 5'h1E, 5'h00, 5'h00, 9, 1'b0);
      vecs[4] = mk(20'hF00F0, 2'd3, 1'b1, 2, 5'h0D, 5'h1F, 5'h00, 5'h00, 8, 1'b0);
      vecs[5] = mk(20'h0C0C3, 2'd1, 1'b0, 3, 5'h0A, 5'h00, 5'h01, 5'h00, 3, 1'b0);

      reset = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; weight_sel = '0;
      invert = 1'b0; num_patterns = '0; pat_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;

      check("rst.pat_data",  pat_data,  0);
      check("rst.pat_valid", pat_valid, 0);
      check("rst.busy",      busy,      0);
      check("rst.done",      done,      0);
      check("rst.seed_zero", seed_zero, 0);
      check_stats("rst", 0, 0);

      // table-driven bursts with pat_ready held high
      for (int v = 0; v < 6; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         do_start(vecs[v].seed, vecs[v].wsel, vecs[v].inv, vecs[v].num);
         for (int b = 0; b < vecs[v].num; b++) begin
            check($sformatf("%s.valid%0d", tag, b), pat_valid, 1);
            check($sformatf("%s.data%0d", tag, b), pat_data, vecs[v].beats[b]);
            check($sformatf("%s.done_early%0d", tag, b), done, 0);
            tick();
         end
         check({tag, ".done"},      done,      1);
         check({tag, ".busy_done"}, busy,      1);
         check({tag, ".valid_done"}, pat_valid, 0);
         tick();
         check({tag, ".done_clr"},  done,      0);
         check({tag, ".busy_clr"},  busy,      0);
         check({tag, ".seed_zero"}, seed_zero, vecs[v].sz);
         check_stats(tag, vecs[v].num, vecs[v].ones);
      end

      // backpressure 1,0,0,1,1 with a start pulse that must be ignored
      begin
         logic       rdy [5];
         logic [4:0] exp [5];
         rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
         exp = '{5'h0A, 5'h00, 5'h00, 5'h00, 5'h01};
         do_start(20'h0C0C3, 2'd1, 1'b0, 3);
         for (int c = 0; c < 5; c++) begin
            pat_ready = rdy[c];
            start     = (c == 2);
            seed      = 20'hFFFFF;
            check($sformatf("stall.data%0d", c), pat_data, exp[c]);
            check($sformatf("stall.valid%0d", c), pat_valid, 1);
            tick();
         end
         start = 1'b0; pat_ready = 1'b1;
         check("stall.done", done, 1);
         tick();
         check("stall.busy_clr", busy, 0);
         check_stats("stall", 3, 3);
      end

      // free-running burst, then abort while stalled
      begin
         logic [4:0] e;
         do_start(20'h00008, 2'd0, 1'b0, 0);
         for (int t = 0; t < 18; t++) begin
            e = '0;
            if (t % 4 == 0 && t <= 16) e[t/4] = 1'b1;
            if (t == 17) e = 5'h01;
            check($sformatf("free.data%0d", t), pat_data, e);
            check($sformatf("free.done%0d", t), done, 0);
            tick();
         end
         pat_ready = 1'b0; abort = 1'b1;
         tick();
         abort = 1'b0; pat_ready = 1'b1;
         check("free.abort_busy", busy, 0);
         check("free.abort_done", done, 0);
         check_stats("free", 18, 6);
      end

      // abort coincident with the last accept
      do_start(20'h00008, 2'd0, 1'b0, 2);
      check("abl.data0", pat_data, 5'h01);
      tick();
      abort = 1'b1;
      check("abl.data1", pat_data, 5'h00);
      tick();
      abort = 1'b0;
      check("abl.busy",  busy,      0);
      check("abl.done",  done,      0);
      check("abl.valid", pat_valid, 0);
      check_stats("abl", 2, 1);
      tick();
      check("abl.done_late", done, 0);

      // reset in the middle of an inverted zero-seed burst
      do_start(20'h00000, 2'd0, 1'b1, 0);
      check("rmid.seed_zero", seed_zero, 1);
      check("rmid.data0", pat_data, 5'h1F);
      tick();
      check("rmid.data1", pat_data, 5'h1F);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rmid.pat_data",  pat_data,  0);
      check("rmid.pat_valid", pat_valid, 0);
      check("rmid.busy",      busy,      0);
      check("rmid.done",      done,      0);
      check("rmid.seed_zero", seed_zero, 0);
      check_stats("rmid", 0, 0);
      tick();
      check("rmid.done_late", done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
